// File: rtl/divider_seq_param.sv
// Multi-cycle radix-2 restoring divider, signed/unsigned per request, valid/ready on both sides.
// Optional `DIVIDER_EARLY_OUT_EN: skips CALC when |a| < |b| and trims iterations to the significant bits of |a|.
module divider_seq_param #(
    parameter int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quo,
    output logic [WIDTH-1:0] out_rem,
    output logic             out_dbz,
    output logic             out_ovf,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
        logic signed [WIDTH-1:0] s;
        s = -$signed(x);
        return s;
    endfunction

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic neg);
        return neg ? negate(x) : x;
    endfunction

`ifdef DIVIDER_EARLY_OUT_EN
    function automatic logic [CNT_W-1:0] lzc(input logic [WIDTH-1:0] x);
        logic [CNT_W-1:0] n;
        logic             found;
        n     = '0;
        found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!found) begin
                if (x[i]) found = 1'b1;
                else      n = n + CNT_W'(1);
            end
        end
        return n;
    endfunction
`endif

    state_t state, state_nxt;

    logic             sgn_q, sign_a_q, sign_b_q, dbz_q, ovf_q;
    logic [WIDTH-1:0] a_q, bmag_q, dvd_q, rem_q, quo_q;
    logic [CNT_W-1:0] cnt_q;

    logic             a_neg, b_neg, b_zero, ovf_case, skip_calc;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   shifted;
    logic signed [WIDTH:0] diff;
    logic             trial_ok;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    assign a_neg    = in_signed & in_a[WIDTH-1];
    assign b_neg    = in_signed & in_b[WIDTH-1];
    assign a_mag    = magnitude(in_a, a_neg);
    assign b_mag    = magnitude(in_b, b_neg);
    assign b_zero   = (in_b == '0);
    assign ovf_case = in_signed & (in_a == MIN_VAL) & (in_b == {WIDTH{1'b1}});

`ifdef DIVIDER_EARLY_OUT_EN
    logic             early;
    logic [CNT_W-1:0] lz;
    assign early     = !b_zero && (a_mag < b_mag);
    assign lz        = lzc(a_mag);
    assign skip_calc = b_zero | ovf_case | early;
`else
    assign skip_calc = b_zero | ovf_case;
`endif

    // One extra bit on the trial subtract so its sign is the borrow.
    assign shifted  = {rem_q, dvd_q[WIDTH-1]};
    assign diff     = $signed(shifted) - $signed({1'b0, bmag_q});
    assign trial_ok = ~diff[WIDTH];

    assign quo_fix = (sgn_q & (sign_a_q ^ sign_b_q)) ? negate(quo_q) : quo_q;
    assign rem_fix = (sgn_q & sign_a_q & (rem_q != '0)) ? negate(rem_q) : rem_q;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = skip_calc ? FIX : CALC;
            CALC: if (cnt_q == CNT_W'(1)) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sgn_q    <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            dbz_q    <= 1'b0;
            ovf_q    <= 1'b0;
            a_q      <= '0;
            bmag_q   <= '0;
            dvd_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            out_quo  <= '0;
            out_rem  <= '0;
            out_dbz  <= 1'b0;
            out_ovf  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_q      <= in_a;
                    sgn_q    <= in_signed;
                    sign_a_q <= a_neg;
                    sign_b_q <= b_neg;
                    bmag_q   <= b_mag;
                    dbz_q    <= b_zero;
                    ovf_q    <= ovf_case;
                    quo_q    <= '0;
`ifdef DIVIDER_EARLY_OUT_EN
                    rem_q    <= early ? a_mag : '0;
                    dvd_q    <= a_mag << lz;
                    cnt_q    <= CNT_INIT - lz;
`else
                    rem_q    <= '0;
                    dvd_q    <= a_mag;
                    cnt_q    <= CNT_INIT;
`endif
                end
                CALC: begin
                    rem_q <= trial_ok ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
                    quo_q <= {quo_q[WIDTH-2:0], trial_ok};
                    dvd_q <= {dvd_q[WIDTH-2:0], 1'b0};
                    cnt_q <= cnt_q - CNT_W'(1);
                end
                // Special cases override the iterated result.
                FIX: begin
                    out_dbz <= dbz_q;
                    out_ovf <= ovf_q & ~dbz_q;
                    if (dbz_q) begin
                        out_quo <= {WIDTH{1'b1}};
                        out_rem <= a_q;
                    end else if (ovf_q) begin
                        out_quo <= MIN_VAL;
                        out_rem <= '0;
                    end else begin
                        out_quo <= quo_fix;
                        out_rem <= rem_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/divider_seq_param.md
Name: divider_seq_param

Overview:
- Parameterised multi-cycle radix-2 restoring divider.
- Handles signed (2's complement) or unsigned operands, selected per operation.
- Uses a valid/ready handshake on both the request and result sides.
- Sits behind the ALU/MDU issue logic as the shared divide unit. It replaces fixed 32-bit dividers that had no handshake and no divide-by-zero or overflow handling.

Parameters:
- WIDTH, 32, operand width in bits for dividend, divisor, quotient and remainder (>= 4).
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; not overridden).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request.
- in_signed  in  1  1 = signed operands, 0 = unsigned.
- in_a  in  WIDTH  dividend.
- in_b  in  WIDTH  divisor.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_quo  out  WIDTH  quotient.
- out_rem  out  WIDTH  remainder.
- out_dbz  out  1  divisor was zero.
- out_ovf  out  1  signed overflow (MIN / -1).
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst==0 at a clock edge) takes priority over everything:
  - state=IDLE.
  - in_ready=1, out_valid=0, busy=0.
  - out_quo=0, out_rem=0, out_dbz=0, out_ovf=0.
  - Internal rem/quo/divisor registers and counter are cleared.
  - Reset mid-operation abandons the operation; no result is produced.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - in_ready=1.
  - An accept (in_valid & in_ready) latches operands. In signed mode it also latches the operand signs and the magnitudes (2's-complement negation of a negative operand).
  - Normal accept: counter=WIDTH, go to CALC.
  - b==0: go to FIX and skip CALC.
  - Signed a==MIN with b==-1: go to FIX and skip CALC.
- CALC:
  - One quotient bit per cycle, MSB first.
  - Shift partial remainder left, bringing in the next dividend bit.
  - Trial subtract the divisor magnitude in a WIDTH+1-bit subtractor.
  - If the result is non-negative, keep the difference and set the quotient bit to 1; otherwise keep the remainder and set the bit to 0.
  - Decrement counter; at counter==1, go to FIX.
- FIX: sign correction and special cases; loads the out_* registers; go to DONE.
  - Quotient truncates toward zero and is negated iff signed & (sign_a ^ sign_b).
  - Remainder takes the sign of the dividend; it is negated iff signed & sign_a & rem!=0.
  - Divide by zero: out_quo = all ones, out_rem = in_a (original value), out_dbz=1.
  - Signed overflow: out_quo = MIN (1 followed by zeros), out_rem=0, out_ovf=1.
  - Unsigned mode never raises out_ovf.
- DONE:
  - out_valid=1; outputs stay stable while out_valid & !out_ready.
  - On out_ready, go to IDLE; out_valid drops next cycle and the out_* registers hold their values.
- Latency, accept edge to out_valid high:
  - Normal: WIDTH+2 cycles (1 load, WIDTH iterations, 1 fix).
  - Special cases: 2 cycles.
- Throughput: one operation in flight.
  - in_ready=0 in CALC, FIX and DONE.
  - No request is accepted in the same cycle a result is consumed; IDLE is always re-entered first.
- Identity check: for every non-special case, a == quo*b + rem holds in the selected signedness, and |rem| < |b|.

Optional Feature:
- DIVIDER_EARLY_OUT_EN
- Defined:
  - At accept, if |a| < |b| (unsigned magnitude compare, b!=0), go directly to FIX with quo=0, rem=a.
  - Latency for that case is 2 cycles.
  - Also, CALC counter starts at WIDTH minus the leading-zero count of |a|, with the dividend pre-shifted accordingly. Latency becomes (significant bits of |a|)+2.
- Not defined: fixed WIDTH+2 latency for all non-special cases. Results are bit-identical either way; only timing differs.

Test Plan:
- WIDTH=32, unsigned, a=100, b=7, out_ready=1 -> out_valid at accept+34, quo=14, rem=2, dbz=0, ovf=0.
- WIDTH=32, signed, a=-100, b=7 -> quo=-14 (0xFFFFFFF2), rem=-2 (0xFFFFFFFE). Then a=100, b=-7 -> quo=-14, rem=2.
- WIDTH=8, signed, a=0x80, b=0xFF -> out_valid at accept+2, quo=0x80, rem=0, ovf=1. Same operands unsigned -> quo=0, rem=0x80, ovf=0.
- WIDTH=32, b=0, a=0x12345678, either mode -> out_valid at accept+2, quo=0xFFFFFFFF, rem=0x12345678, dbz=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> outputs stable and in_ready=0 throughout. Assert in_valid during DONE -> not accepted. Raise out_ready -> IDLE next cycle, then the request is accepted.
- Drive rst=0 for one cycle mid-CALC (iteration 10) -> next cycle IDLE, out_valid=0, in_ready=1. A new request (a=9, b=3) then completes with quo=3, rem=0.
